// File: rtl/stack_seq_pkg.sv
// Shared encodings for the stack-sequencing FSM interface and the
// read-tag record that tracks an in-flight pop through memory latency.
package stack_seq_pkg;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'b00,
    PH_PCL   = 2'b01,
    PH_PCH   = 2'b10,
    PH_FLAGS = 2'b11
  } phase_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b11
  } op_e;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam logic [11:0] SP_INIT    = 12'hFFF;

  typedef struct packed {
    logic       valid;
    logic [1:0] slot;
    logic       last;
    logic       single;
  } rd_tag_t;

  // Saturates at 3 so an over-long sequence never aliases back onto slot 0.
  function automatic logic [1:0] next_slot(input logic [1:0] k);
    return (k == 2'd3) ? 2'd3 : k + 2'd1;
  endfunction

endpackage

// File: rtl/stack_pointer_reg.sv
// Stack pointer with post-decrement push / pre-increment pop, modulo wrap,
// and sticky overflow/underflow flags.
module stack_pointer_reg #(
  parameter int                ADDR_W  = 12,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic              err_ovf,
  output logic              err_udf
);

  // SP update and sticky wrap detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sp      <= SP_INIT;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else if (inc) begin
      sp <= sp + ADDR_W'(1'b1);
      if (sp == SP_INIT) begin
        err_udf <= 1'b1;
      end
    end else if (dec) begin
      sp <= sp - ADDR_W'(1'b1);
      if (sp == {ADDR_W{1'b0}}) begin
        err_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/stack_access_unit.sv
// Memory-stage stack access: drives push/pop beats to data memory, owns SP,
// and reassembles popped PC/flags/register words into one-cycle load pulses.
module stack_access_unit #(
  parameter int                ADDR_W  = 12,
  parameter int                DATA_W  = 16,
  parameter int                PC_W    = 32,
  parameter int                FLAG_W  = 3,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        phase,
  input  logic [1:0]        stack_op,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] sp_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              pc_load,
  output logic [FLAG_W-1:0] flags_out,
  output logic              flags_load,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              reg_load,
  output logic              err_ovf,
  output logic              err_udf
);
  import stack_seq_pkg::*;

  logic [1:0]        prev_phase_r;
  logic [1:0]        slot_r;
  logic              with_flags_r;
  logic              block_r;
  logic [1:0]        cur_slot_s;
  logic              cur_wf_s;
  logic              seq_s;
  logic              single_s;
  logic              start_s;
  logic              push_s;
  logic              pop_s;
  logic              last_s;
  logic [DATA_W-1:0] pc_lo_r;
  logic [DATA_W-1:0] pc_hi_r;
  rd_tag_t           rd_r;

  stack_pointer_reg #(
    .ADDR_W  (ADDR_W),
    .SP_INIT (SP_INIT)
  ) u_sp (
    .clk     (clk),
    .rst     (rst),
    .inc     (pop_s),
    .dec     (push_s),
    .sp      (sp_out),
    .err_ovf (err_ovf),
    .err_udf (err_udf)
  );

  // Beat decode: a sequence aborted by reset stays blocked until phase is idle
  always_comb begin
    seq_s    = !rst && !block_r && (phase != PH_IDLE);
    single_s = !rst && (phase == PH_IDLE);
    start_s  = seq_s && (prev_phase_r == PH_IDLE);
    if (start_s) begin
      cur_slot_s = 2'd0;
      cur_wf_s   = (phase == PH_FLAGS);
    end else begin
      cur_slot_s = slot_r;
      cur_wf_s   = with_flags_r;
    end
    push_s = (seq_s || single_s) && (stack_op == OP_PUSH);
    pop_s  = (seq_s || single_s) && (stack_op == OP_POP);
    last_s = seq_s && (cur_wf_s ? (cur_slot_s == 2'd2) : (cur_slot_s == 2'd1));
  end

  // Memory address, strobes and write data for the current beat
  always_comb begin
    mem_we    = push_s;
    mem_re    = pop_s;
    mem_wdata = {DATA_W{1'b0}};
    if (pop_s) begin
      mem_addr = sp_out + ADDR_W'(1'b1);
    end else if (push_s) begin
      mem_addr = sp_out;
    end else begin
      mem_addr = {ADDR_W{1'b0}};
    end
    if (push_s) begin
      case (phase)
        PH_FLAGS: mem_wdata = {{(DATA_W-FLAG_W){1'b0}}, flags_in};
        PH_PCH:   mem_wdata = pc_in[PC_W-1:DATA_W];
        PH_PCL:   mem_wdata = pc_in[DATA_W-1:0];
        default:  mem_wdata = reg_wdata;
      endcase
    end else begin
      mem_wdata = {DATA_W{1'b0}};
    end
  end

  // Sequence tracking: previous phase, slot counter, with_flags, reset block
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_phase_r <= PH_IDLE;
      slot_r       <= 2'd0;
      with_flags_r <= 1'b0;
      block_r      <= 1'b1;
    end else begin
      prev_phase_r <= phase;
      if (phase == PH_IDLE) begin
        block_r      <= 1'b0;
        slot_r       <= 2'd0;
        with_flags_r <= 1'b0;
      end else if (seq_s) begin
        slot_r       <= next_slot(cur_slot_s);
        with_flags_r <= cur_wf_s;
      end
    end
  end

  // Read-tag pipeline and capture of returning data into load pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_r.valid  <= 1'b0;
      rd_r.slot   <= 2'd0;
      rd_r.last   <= 1'b0;
      rd_r.single <= 1'b0;
      pc_lo_r     <= {DATA_W{1'b0}};
      pc_hi_r     <= {DATA_W{1'b0}};
      pc_out      <= {PC_W{1'b0}};
      flags_out   <= {FLAG_W{1'b0}};
      reg_rdata   <= {DATA_W{1'b0}};
      pc_load     <= 1'b0;
      flags_load  <= 1'b0;
      reg_load    <= 1'b0;
    end else begin
      rd_r.valid  <= pop_s;
      rd_r.slot   <= cur_slot_s;
      rd_r.last   <= last_s;
      rd_r.single <= single_s;
      pc_load     <= 1'b0;
      flags_load  <= 1'b0;
      reg_load    <= 1'b0;
      if (rd_r.valid) begin
        if (rd_r.single) begin
          reg_rdata <= mem_rdata;
          reg_load  <= 1'b1;
        end else begin
          // PC halves are staged so pc_out only changes together with pc_load
          case (rd_r.slot)
            2'd0: pc_lo_r <= mem_rdata;
            2'd1: begin
              if (rd_r.last) begin
                pc_out  <= {mem_rdata, pc_lo_r};
                pc_load <= 1'b1;
              end else begin
                pc_hi_r <= mem_rdata;
              end
            end
            2'd2: begin
              if (rd_r.last) begin
                pc_out     <= {pc_hi_r, pc_lo_r};
                flags_out  <= mem_rdata[FLAG_W-1:0];
                pc_load    <= 1'b1;
                flags_load <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_stack_access_unit.sv
// Scoreboard bench for stack_access_unit: directed CALL/RET, INT/RTI,
// single PUSH/POP, wrap errors and reset mid-sequence.
module tb_stack_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  phase;
  logic [1:0]  stack_op;
  logic [31:0] pc_in;
  logic [2:0]  flags_in;
  logic [15:0] reg_wdata;
  logic [15:0] mem_rdata;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [11:0] sp_out;
  logic [31:0] pc_out;
  logic        pc_load;
  logic [2:0]  flags_out;
  logic        flags_load;
  logic [15:0] reg_rdata;
  logic        reg_load;
  logic        err_ovf;
  logic        err_udf;

  always #5 clk = ~clk;

  stack_access_unit dut (
    .clk        (clk),
    .rst        (rst),
    .phase      (phase),
    .stack_op   (stack_op),
    .pc_in      (pc_in),
    .flags_in   (flags_in),
    .reg_wdata  (reg_wdata),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .sp_out     (sp_out),
    .pc_out     (pc_out),
    .pc_load    (pc_load),
    .flags_out  (flags_out),
    .flags_load (flags_load),
    .reg_rdata  (reg_rdata),
    .reg_load   (reg_load),
    .err_ovf    (err_ovf),
    .err_udf    (err_udf)
  );

  // Synchronous data memory: read data valid the cycle after mem_re
  logic [15:0] mem [0:4095];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {logic [11:0] addr; logic [15:0] data;} wr_t;
  typedef struct {logic [31:0] val; int cyc;} ld_t;
  wr_t         wr_q[$];
  logic [11:0] rd_q[$];
  ld_t         pc_q[$];
  ld_t         fl_q[$];
  ld_t         reg_q[$];
  wr_t         mw;
  ld_t         ml;
  logic [11:0] ma;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic unexpected(input string name);
    tot_cnt++;
    $display("FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor: pop expected responses whenever the DUT presents one
  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_q.size() == 0) unexpected("mem_we");
      else begin
        mw = wr_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mw.addr));
        chk("wr_data", 32'(mem_wdata), 32'(mw.data));
      end
    end
    if (mem_re) begin
      if (rd_q.size() == 0) unexpected("mem_re");
      else begin
        ma = rd_q.pop_front();
        chk("rd_addr", 32'(mem_addr), 32'(ma));
      end
    end
    if (pc_load) begin
      if (pc_q.size() == 0) unexpected("pc_load");
      else begin
        ml = pc_q.pop_front();
        chk("pc_out", pc_out, ml.val);
        chk("pc_load_cycle", 32'(cyc), 32'(ml.cyc));
      end
    end
    if (flags_load) begin
      if (fl_q.size() == 0) unexpected("flags_load");
      else begin
        ml = fl_q.pop_front();
        chk("flags_out", 32'(flags_out), ml.val);
        chk("flags_load_cycle", 32'(cyc), 32'(ml.cyc));
      end
    end
    if (reg_load) begin
      if (reg_q.size() == 0) unexpected("reg_load");
      else begin
        ml = reg_q.pop_front();
        chk("reg_rdata", 32'(reg_rdata), ml.val);
        chk("reg_load_cycle", 32'(cyc), 32'(ml.cyc));
      end
    end
  end

  task automatic exp_wr(input logic [11:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic exp_ld(input int which, input logic [31:0] v, input int c);
    ld_t l;
    l.val = v;
    l.cyc = c;
    case (which)
      0:       pc_q.push_back(l);
      1:       fl_q.push_back(l);
      default: reg_q.push_back(l);
    endcase
  endtask

  task automatic beat(input logic [1:0] ph, input logic [1:0] op);
    phase    = ph;
    stack_op = op;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    phase    = 2'b00;
    stack_op = 2'b00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_call();
    pc_in = 32'h0001_2345;
    exp_wr(12'hFFF, 16'h0001);
    exp_wr(12'hFFE, 16'h2345);
    beat(2'b10, 2'b10);
    beat(2'b01, 2'b10);
    idle(3);
    chk("sp_after_call", 32'(sp_out), 32'h0000_0FFD);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    rst       = 1'b1;
    phase     = 2'b00;
    stack_op  = 2'b00;
    pc_in     = 32'h0;
    flags_in  = 3'b000;
    reg_wdata = 16'h0000;
    @(posedge clk);
    #1;
    chk("rst_sp", 32'(sp_out), 32'h0000_0FFF);
    chk("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
    chk("rst_loads", {29'd0, pc_load, flags_load, reg_load}, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_errs", {30'd0, err_ovf, err_udf}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // 1: CALL
    do_call();

    // 2: RET
    rd_q.push_back(12'hFFE);
    rd_q.push_back(12'hFFF);
    beat(2'b10, 2'b11);
    exp_ld(0, 32'h0001_2345, cyc + 2);
    beat(2'b01, 2'b11);
    idle(5);
    chk("sp_after_ret", 32'(sp_out), 32'h0000_0FFF);
    chk("pc_out_hold", pc_out, 32'h0001_2345);

    // 3: INT then RTI
    flags_in = 3'b101;
    pc_in    = 32'hABCD_0010;
    exp_wr(12'hFFF, 16'h0005);
    exp_wr(12'hFFE, 16'hABCD);
    exp_wr(12'hFFD, 16'h0010);
    beat(2'b11, 2'b10);
    beat(2'b10, 2'b10);
    beat(2'b01, 2'b10);
    idle(2);
    chk("sp_after_int", 32'(sp_out), 32'h0000_0FFC);
    rd_q.push_back(12'hFFD);
    rd_q.push_back(12'hFFE);
    rd_q.push_back(12'hFFF);
    beat(2'b11, 2'b11);
    beat(2'b10, 2'b11);
    exp_ld(0, 32'hABCD_0010, cyc + 2);
    exp_ld(1, 32'h0000_0005, cyc + 2);
    beat(2'b01, 2'b11);
    idle(5);
    chk("sp_after_rti", 32'(sp_out), 32'h0000_0FFF);

    // 4: single PUSH then POP
    reg_wdata = 16'h55AA;
    exp_wr(12'hFFF, 16'h55AA);
    beat(2'b00, 2'b10);
    chk("sp_after_push", 32'(sp_out), 32'h0000_0FFE);
    rd_q.push_back(12'hFFF);
    exp_ld(2, 32'h0000_55AA, cyc + 2);
    beat(2'b00, 2'b11);
    idle(4);
    chk("sp_after_pop", 32'(sp_out), 32'h0000_0FFF);

    // 5: underflow then overflow wrap
    rd_q.push_back(12'h000);
    exp_ld(2, 32'h0000_0000, cyc + 2);
    beat(2'b00, 2'b11);
    chk("sp_udf_wrap", 32'(sp_out), 32'h0000_0000);
    chk("err_udf_set", 32'(err_udf), 32'd1);
    chk("err_ovf_clear", 32'(err_ovf), 32'd0);
    idle(3);
    reg_wdata = 16'h1234;
    exp_wr(12'h000, 16'h1234);
    beat(2'b00, 2'b10);
    chk("sp_ovf_wrap", 32'(sp_out), 32'h0000_0FFF);
    chk("err_ovf_set", 32'(err_ovf), 32'd1);
    idle(3);
    chk("err_udf_sticky", 32'(err_udf), 32'd1);

    // 6: reset during second RTI beat
    flags_in = 3'b011;
    pc_in    = 32'h1111_2222;
    exp_wr(12'hFFF, 16'h0003);
    exp_wr(12'hFFE, 16'h1111);
    exp_wr(12'hFFD, 16'h2222);
    beat(2'b11, 2'b10);
    beat(2'b10, 2'b10);
    beat(2'b01, 2'b10);
    idle(2);
    chk("sp_before_abort", 32'(sp_out), 32'h0000_0FFC);
    chk("err_ovf_still", 32'(err_ovf), 32'd1);
    rd_q.push_back(12'hFFD);
    beat(2'b11, 2'b11);
    rst = 1'b1;
    beat(2'b10, 2'b11);
    rst = 1'b0;
    chk("sp_after_abort", 32'(sp_out), 32'h0000_0FFF);
    chk("errs_after_abort", {30'd0, err_ovf, err_udf}, 32'd0);
    beat(2'b01, 2'b11);
    idle(5);
    chk("sp_after_block", 32'(sp_out), 32'h0000_0FFF);
    do_call();

    idle(4);
    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("pc_q_empty", 32'(pc_q.size()), 32'd0);
    chk("fl_q_empty", 32'(fl_q.size()), 32'd0);
    chk("reg_q_empty", 32'(reg_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
